// File: rtl/fifo_rd_ctrl_pkg.sv
// Shared definitions for the FIFO read-side controller: FSM encoding and default sizing.
package fifo_rd_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'b00,
    StPop      = 2'b01,
    StWaitBusy = 2'b10,
    StWaitDone = 2'b11
  } state_e;

  localparam int unsigned DefDataWidth     = 8;
  localparam int unsigned DefTimeoutCycles = 32;

endpackage

// File: rtl/fifo_rd_ctrl_tmo.sv
// Handoff timeout counter: counts enabled cycles and flags expiry on the last allowed one.
module fifo_rd_ctrl_tmo
  import fifo_rd_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
  input  logic rclk,
  input  logic rrst_n,
  input  logic cnt_en,
  input  logic cnt_clr,
  output logic expire
);

  logic [7:0] cnt_q, cnt_d;

  // Clear has priority so a new wait always starts from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (cnt_en) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Counter register.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires during the TIMEOUT_CYCLES-th counted cycle, so the abort lands on the following edge.
  assign expire = cnt_en && (cnt_q == 8'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/fifo_rd_ctrl.sv
// FIFO read-side controller: pops one word at a time and hands it to a serial transmitter.
// Optional handoff timeout enabled by defining FIFO_RD_CTRL_TIMEOUT_EN.
module fifo_rd_ctrl
  import fifo_rd_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DefDataWidth,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  ctrl_en,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_busy,
  input  logic                  err_clr,
  output logic                  timeout_err
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  armed_q;
  logic                  tmo_expire;

  // Next-state logic; the head word is captured only on the IDLE->POP edge.
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    unique case (state_q)
      StIdle: begin
        // armed_q holds off the first pop until the second edge after reset release
        if (armed_q && ctrl_en && !rempty && !tx_busy) begin
          state_d   = StPop;
          tx_data_d = rdata;
        end
      end
      StPop: state_d = StWaitBusy;
      StWaitBusy: begin
        if (tx_busy) begin
          state_d = StWaitDone;
        end else if (tmo_expire) begin
          state_d = StIdle;
        end
      end
      StWaitDone: begin
        if (!tx_busy) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, data and arm registers.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q   <= StIdle;
      tx_data_q <= '0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      armed_q   <= 1'b1;
    end
  end

  // Outputs decode straight from the state register so reset clears them asynchronously.
  assign rinc     = (state_q == StPop);
  assign tx_valid = (state_q == StPop) || (state_q == StWaitBusy);
  assign tx_data  = tx_data_q;

`ifdef FIFO_RD_CTRL_TIMEOUT_EN
  logic timeout_err_q, timeout_err_d;

  fifo_rd_ctrl_tmo #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .rclk    (rclk),
    .rrst_n  (rrst_n),
    .cnt_en  ((state_q == StWaitBusy) && !tx_busy),
    .cnt_clr (state_q != StWaitBusy),
    .expire  (tmo_expire)
  );

  // Sticky error; a timeout in the same cycle as a clear wins.
  always_comb begin
    timeout_err_d = timeout_err_q;
    if (err_clr) begin
      timeout_err_d = 1'b0;
    end
    if (tmo_expire) begin
      timeout_err_d = 1'b1;
    end
  end

  // Error flag register.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  logic       unused_err_clr;
  logic [7:0] unused_tmo_cfg;

  assign tmo_expire     = 1'b0;
  assign timeout_err    = 1'b0;
  assign unused_err_clr = err_clr;
  assign unused_tmo_cfg = 8'(TIMEOUT_CYCLES);
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl: vector table plus hand-written multi-cycle sequences.
module tb_fifo_rd_ctrl;

  logic       rclk = 1'b0;
  logic       rrst_n;
  logic       ctrl_en;
  logic       rempty;
  logic [7:0] rdata;
  logic       rinc;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_busy;
  logic       err_clr;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;

  fifo_rd_ctrl #(
    .DATA_WIDTH     (8),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .rclk        (rclk),
    .rrst_n      (rrst_n),
    .ctrl_en     (ctrl_en),
    .rempty      (rempty),
    .rdata       (rdata),
    .rinc        (rinc),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_busy     (tx_busy),
    .err_clr     (err_clr),
    .timeout_err (timeout_err)
  );

  always #5 rclk = ~rclk;

  typedef struct {
    logic       en;
    logic       empty;
    logic [7:0] data;
    logic       busy;
    logic       exp_rinc;
    logic       exp_valid;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  logic [7:0] q[$];
  logic [7:0] exp_words[3];
  int         pop_cyc[$];
  logic [7:0] pop_dat[$];
  int         busy_cnt;
  logic       valid_prev;
  logic       rinc_was;
  int         hits;

  initial begin
    // Starting in POP with 8'hA5 in flight.
    vecs[0]  = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5};
    vecs[1]  = '{1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 8'hA5};
    vecs[2]  = '{1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 8'hA5};
    vecs[3]  = '{1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 8'hA5};
    vecs[4]  = '{1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 8'hA5};
    vecs[5]  = '{1'b1, 1'b0, 8'h11, 1'b0, 1'b1, 1'b1, 8'h11};
    vecs[6]  = '{1'b0, 1'b0, 8'h22, 1'b0, 1'b0, 1'b1, 8'h11};
    vecs[7]  = '{1'b0, 1'b0, 8'h22, 1'b1, 1'b0, 1'b0, 8'h11};
    vecs[8]  = '{1'b0, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0, 8'h11};
    vecs[9]  = '{1'b0, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0, 8'h11};
    vecs[10] = '{1'b1, 1'b0, 8'h22, 1'b1, 1'b0, 1'b0, 8'h11};
    vecs[11] = '{1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 8'h11};
    vecs[12] = '{1'b1, 1'b0, 8'h22, 1'b0, 1'b1, 1'b1, 8'h22};
    vecs[13] = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'h22};
    vecs[14] = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h22};
    vecs[15] = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h22};
    vecs[16] = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h22};

    // Reset state.
    rrst_n = 1'b0; ctrl_en = 1'b1; rempty = 1'b0; rdata = 8'hA5; tx_busy = 1'b0; err_clr = 1'b0;
    tick();
    tick();
    chk("reset_rinc", 32'(rinc), 32'd0);
    chk("reset_valid", 32'(tx_valid), 32'd0);
    chk("reset_data", 32'(tx_data), 32'd0);
    chk("reset_err", 32'(timeout_err), 32'd0);

    // Release mid-cycle; first pop must wait for the second edge.
    rrst_n = 1'b1;
    tick();
    chk("arm_edge1_rinc", 32'(rinc), 32'd0);
    tick();
    chk("arm_edge2_rinc", 32'(rinc), 32'd1);
    chk("arm_edge2_valid", 32'(tx_valid), 32'd1);
    chk("arm_edge2_data", 32'(tx_data), 32'hA5);

    // Vector table.
    for (int i = 0; i < 17; i++) begin
      ctrl_en = vecs[i].en; rempty = vecs[i].empty; rdata = vecs[i].data; tx_busy = vecs[i].busy;
      tick();
      chk($sformatf("row%0d_rinc", i), 32'(rinc), 32'(vecs[i].exp_rinc));
      chk($sformatf("row%0d_valid", i), 32'(tx_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("row%0d_data", i), 32'(tx_data), 32'(vecs[i].exp_data));
      chk($sformatf("row%0d_err", i), 32'(timeout_err), 32'd0);
    end

    // Three words with a transmitter that goes busy for 10 cycles after seeing tx_valid.
    exp_words[0] = 8'h11; exp_words[1] = 8'h22; exp_words[2] = 8'h33;
    q.push_back(8'h11); q.push_back(8'h22); q.push_back(8'h33);
    busy_cnt = 0; valid_prev = 1'b0; rinc_was = 1'b0; ctrl_en = 1'b1;
    for (int c = 0; c < 45; c++) begin
      rempty  = (q.size() == 0);
      rdata   = (q.size() != 0) ? q[0] : 8'h00;
      tx_busy = (busy_cnt > 0);
      tick();
      if (rinc_was && q.size() != 0) void'(q.pop_front());
      rinc_was = rinc;
      if (rinc) begin
        pop_cyc.push_back(c);
        pop_dat.push_back(tx_data);
      end
      if (busy_cnt > 0) busy_cnt--;
      else if (valid_prev) busy_cnt = 10;
      valid_prev = tx_valid;
    end
    chk("burst_pop_count", 32'(pop_cyc.size()), 32'd3);
    for (int k = 0; k < 3 && k < pop_cyc.size(); k++) begin
      chk($sformatf("burst_word%0d_data", k), 32'(pop_dat[k]), 32'(exp_words[k]));
      chk($sformatf("burst_word%0d_cycle", k), 32'(pop_cyc[k]), 32'(13 * k));
    end

    // Empty FIFO with ctrl_en held: no pops, nothing offered.
    tx_busy = 1'b0; rempty = 1'b1; ctrl_en = 1'b1; hits = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (rinc || tx_valid) hits++;
    end
    chk("empty_no_rinc", 32'(hits), 32'd0);

    // Asynchronous reset during POP.
    rempty = 1'b0; rdata = 8'h3C;
    tick();
    chk("pre_rst_rinc", 32'(rinc), 32'd1);
    #2 rrst_n = 1'b0;
    #1;
    chk("async_rst_rinc", 32'(rinc), 32'd0);
    chk("async_rst_valid", 32'(tx_valid), 32'd0);
    chk("async_rst_data", 32'(tx_data), 32'd0);
    tick();
    rdata = 8'h5A; rrst_n = 1'b1;
    tick();
    chk("post_rst_edge1_rinc", 32'(rinc), 32'd0);
    chk("post_rst_edge1_valid", 32'(tx_valid), 32'd0);
    tick();
    chk("post_rst_edge2_rinc", 32'(rinc), 32'd1);
    chk("post_rst_edge2_data", 32'(tx_data), 32'h5A);

    // Transmitter never responds.
    rempty = 1'b1; tx_busy = 1'b0;
`ifdef FIFO_RD_CTRL_TIMEOUT_EN
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk($sformatf("tmo_wait%0d_valid", c), 32'(tx_valid), 32'd1);
      chk($sformatf("tmo_wait%0d_err", c), 32'(timeout_err), 32'd0);
    end
    tick();
    chk("tmo_abort_valid", 32'(tx_valid), 32'd0);
    chk("tmo_abort_err", 32'(timeout_err), 32'd1);
    tick();
    chk("tmo_sticky_err", 32'(timeout_err), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("tmo_clr_err", 32'(timeout_err), 32'd0);
    // Second timeout with err_clr held high: set wins on the abort edge.
    rempty = 1'b0; rdata = 8'h77; err_clr = 1'b1;
    tick();
    rempty = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    chk("tmo_set_wins_err", 32'(timeout_err), 32'd1);
    chk("tmo_set_wins_valid", 32'(tx_valid), 32'd0);
    tick();
    chk("tmo_clr_again_err", 32'(timeout_err), 32'd0);
    err_clr = 1'b0;
`else
    hits = 0;
    for (int c = 0; c < 40; c++) begin
      err_clr = c[0];
      tick();
      if (!tx_valid || timeout_err) hits++;
    end
    err_clr = 1'b0;
    chk("no_tmo_wait_forever", 32'(hits), 32'd0);
    chk("no_tmo_data_held", 32'(tx_data), 32'h5A);
    tx_busy = 1'b1;
    tick();
    chk("no_tmo_done_valid", 32'(tx_valid), 32'd0);
    tx_busy = 1'b0;
    tick();
    chk("no_tmo_idle_rinc", 32'(rinc), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
